// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: memory bus between the access unit (master) and memory (slave).
interface mem_access_unit_if;
   logic        mem_req;
   logic        mem_we;
   logic        mem_ready;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ready);
   modport slave (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: LD/ST/LDI/STI sequencer with one-cycle indirection gap and per-phase bus timeout.
module mem_access_unit #(
   parameter int MAX_WAIT = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [1:0]               op,
   input  logic [15:0]              ea,
   input  logic [15:0]              st_data,
   mem_access_unit_if.master        bus,
   output logic [15:0]              mar,
   output logic [15:0]              mdr,
   output logic                     busy,
   output logic                     done,
   output logic                     err
);
   typedef enum logic [2:0] {IDLE, READ, IND, WRITE, DONE} state_t;
   localparam logic [7:0] LAST = 8'(MAX_WAIT - 1);
   state_t      state, nxt;
   logic [15:0] wdata;
   logic [1:0]  op_r;
   logic [7:0]  cnt;
   logic        phase;
   logic        timeout;
   logic        chain;
   assign timeout       = !bus.mem_ready && cnt == LAST;
   assign chain         = op_r[1] && !phase;
   assign bus.mem_req   = state == READ || state == WRITE;
   assign bus.mem_we    = state == WRITE;
   assign bus.mem_addr  = mar;
   assign bus.mem_wdata = wdata;
   assign busy          = state != IDLE;
   assign done          = state == DONE;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= nxt;
   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:    nxt = start ? (op == 2'b01 ? WRITE : READ) : IDLE;
         READ:    nxt = bus.mem_ready ? (chain ? IND : DONE) : (timeout ? DONE : READ);
         IND:     nxt = op_r[0] ? WRITE : READ;
         WRITE:   nxt = (bus.mem_ready || timeout) ? DONE : WRITE;
         default: nxt = IDLE;
      endcase
   end
   // An aborting cycle only raises err; mar/mdr keep the last completed phase.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         mar   <= '0;
         mdr   <= '0;
         wdata <= '0;
         op_r  <= '0;
         cnt   <= '0;
         phase <= 1'b0;
         err   <= 1'b0;
      end else begin
         case (state)
            IDLE:
               if (start) begin
                  mar   <= ea;
                  wdata <= st_data;
                  op_r  <= op;
                  err   <= 1'b0;
                  cnt   <= '0;
                  phase <= 1'b0;
               end
            READ:
               if (bus.mem_ready) begin
                  mdr <= bus.mem_rdata;
                  if (chain) begin
                     mar   <= bus.mem_rdata;
                     phase <= 1'b1;
                  end
               end else if (timeout) err <= 1'b1;
               else cnt <= cnt + 8'd1;
            IND: cnt <= '0;
            WRITE:
               if (bus.mem_ready) mdr <= wdata;
               else if (timeout) err <= 1'b1;
               else cnt <= cnt + 8'd1;
            default: ;
         endcase
      end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized and directed checks of mem_access_unit against a phase-level model.
module tb_mem_access_unit;
   localparam int MW = 16;
   logic        clk, rst_n, start, busy, done, err;
   logic [1:0]  op;
   logic [15:0] ea, st_data, mar, mdr;
   mem_access_unit_if bus ();
   mem_access_unit #(.MAX_WAIT(MW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .ea(ea), .st_data(st_data),
      .bus(bus), .mar(mar), .mdr(mdr), .busy(busy), .done(done), .err(err)
   );
   int          total, passed;
   int          cyc, reqs, gaps, glitch;
   int          ph_len [2];
   logic [15:0] ph_addr [2];
   logic [15:0] ph_wdata [2];
   logic        ph_we [2];
   logic [15:0] mem [logic [15:0]];
   logic [15:0] m_mdr;
   always #5 clk = ~clk;
   function automatic logic [15:0] rd(input logic [15:0] a);
      return mem.exists(a) ? mem[a] : 16'h0000;
   endfunction
   // Acts as the memory slave for one access; noise drives junk on start/op/ea/st_data while busy.
   task automatic access(input logic [1:0] o, input logic [15:0] a, input logic [15:0] d,
                         input int w0, input int w1, input bit noise);
      int ph, left;
      ph = 0; left = w0; cyc = -1; reqs = 0; gaps = 0; glitch = 0;
      for (int k = 0; k < 2; k++) begin
         ph_len[k] = 0; ph_addr[k] = 'x; ph_wdata[k] = 'x; ph_we[k] = 1'bx;
      end
      @(negedge clk);
      start = 1'b1; op = o; ea = a; st_data = d;
      for (int n = 1; n <= 400; n++) begin
         @(negedge clk);
         start = noise ? 1'($urandom) : 1'b0;
         if (noise) begin
            op = 2'($urandom); ea = 16'($urandom); st_data = 16'($urandom);
         end
         if ((bus.mem_we && !bus.mem_req) || bus.mem_addr !== mar) glitch++;
         if (done) begin
            cyc = n;
            break;
         end
         if (bus.mem_req) begin
            reqs++;
            if (ph < 2) begin
               if (ph_len[ph] == 0) begin
                  ph_addr[ph] = bus.mem_addr; ph_we[ph] = bus.mem_we; ph_wdata[ph] = bus.mem_wdata;
               end
               ph_len[ph]++;
            end
            if (left > 0) begin
               bus.mem_ready = 1'b0; bus.mem_rdata = 16'($urandom); left--;
            end else begin
               bus.mem_ready = 1'b1; bus.mem_rdata = rd(bus.mem_addr);
               if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
               ph++; left = w1;
            end
         end else begin
            bus.mem_ready = 1'($urandom); bus.mem_rdata = 16'($urandom);
            if (reqs > 0) gaps++;
         end
      end
      @(negedge clk);
      start = 1'b0; bus.mem_ready = 1'b0;
   endtask
   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (bus.mem_req !== 1'b0) $display("FAIL reset mem_req: got %b want 0", bus.mem_req); else passed++;
      total++; if (bus.mem_we !== 1'b0) $display("FAIL reset mem_we: got %b want 0", bus.mem_we); else passed++;
      total++; if ({busy, done, err} !== 3'b000) $display("FAIL reset busy/done/err: got %b want 000", {busy, done, err}); else passed++;
      total++; if (mar !== 16'h0 || mdr !== 16'h0) $display("FAIL reset mar/mdr: got %h/%h want 0000/0000", mar, mdr); else passed++;
      total++; if (bus.mem_wdata !== 16'h0) $display("FAIL reset wdata: got %h want 0000", bus.mem_wdata); else passed++;
      @(posedge clk); #3 rst_n = 1'b1;
      m_mdr = 16'h0;
   endtask
   task automatic test_directed;
      mem[16'h3005] = 16'hBEEF;
      access(2'b00, 16'h3005, 16'h0, 2, 0, 1'b0);
      total++; if (reqs !== 3 || ph_we[0] !== 1'b0 || ph_addr[0] !== 16'h3005) $display("FAIL ld bus: got req=%0d we=%b addr=%h want 3 0 3005", reqs, ph_we[0], ph_addr[0]); else passed++;
      total++; if (cyc !== 4) $display("FAIL ld latency: got %0d want 4", cyc); else passed++;
      total++; if (mdr !== 16'hBEEF || err !== 1'b0) $display("FAIL ld result: got mdr=%h err=%b want beef 0", mdr, err); else passed++;
      access(2'b01, 16'h4000, 16'h1234, 0, 0, 1'b0);
      total++; if (reqs !== 1 || ph_we[0] !== 1'b1 || ph_addr[0] !== 16'h4000 || ph_wdata[0] !== 16'h1234) $display("FAIL st bus: got req=%0d we=%b addr=%h wd=%h want 1 1 4000 1234", reqs, ph_we[0], ph_addr[0], ph_wdata[0]); else passed++;
      total++; if (cyc !== 2 || mdr !== 16'h1234) $display("FAIL st result: got cyc=%0d mdr=%h want 2 1234", cyc, mdr); else passed++;
      mem[16'h3010] = 16'h5000; mem[16'h5000] = 16'h00AA;
      access(2'b10, 16'h3010, 16'h0, 0, 0, 1'b0);
      total++; if (ph_addr[0] !== 16'h3010 || ph_addr[1] !== 16'h5000 || gaps !== 1) $display("FAIL ldi bus: got %h %h gap=%0d want 3010 5000 1", ph_addr[0], ph_addr[1], gaps); else passed++;
      total++; if (cyc !== 4 || mar !== 16'h5000 || mdr !== 16'h00AA) $display("FAIL ldi result: got cyc=%0d mar=%h mdr=%h want 4 5000 00aa", cyc, mar, mdr); else passed++;
      mem[16'h3020] = 16'h6000; mem[16'h6000] = 16'h0000;
      access(2'b11, 16'h3020, 16'h7777, 0, 0, 1'b0);
      total++; if (ph_we[0] !== 1'b0 || ph_we[1] !== 1'b1 || ph_addr[1] !== 16'h6000 || ph_wdata[1] !== 16'h7777) $display("FAIL sti bus: got we=%b%b addr=%h wd=%h want 01 6000 7777", ph_we[0], ph_we[1], ph_addr[1], ph_wdata[1]); else passed++;
      total++; if (rd(16'h6000) !== 16'h7777 || cyc !== 4) $display("FAIL sti result: got mem=%h cyc=%0d want 7777 4", rd(16'h6000), cyc); else passed++;
      m_mdr = 16'h7777;
   endtask
   task automatic test_timeout;
      access(2'b00, 16'h3100, 16'h0, MW, 0, 1'b0);
      total++; if (reqs !== MW || cyc !== MW + 1) $display("FAIL timeout length: got req=%0d cyc=%0d want %0d %0d", reqs, cyc, MW, MW + 1); else passed++;
      total++; if (err !== 1'b1 || mdr !== m_mdr) $display("FAIL timeout result: got err=%b mdr=%h want 1 %h", err, mdr, m_mdr); else passed++;
      mem[16'h3101] = 16'h0F0F;
      access(2'b00, 16'h3101, 16'h0, MW - 1, 0, 1'b0);
      total++; if (err !== 1'b0 || mdr !== 16'h0F0F || cyc !== MW + 1) $display("FAIL last-wait ld: got err=%b mdr=%h cyc=%0d want 0 0f0f %0d", err, mdr, cyc, MW + 1); else passed++;
      m_mdr = 16'h0F0F;
   endtask
   task automatic test_random(input int iters);
      logic [1:0]  o;
      logic [15:0] a, d, p, v0, v1, t;
      int          w0, w1, len0, len1, e_cyc;
      bit          two, to0, to1, e_err, wr;
      for (int i = 0; i < iters; i++) begin
         o = 2'($urandom); a = 16'($urandom); d = 16'($urandom); p = 16'($urandom);
         mem[a] = p;
         if (p != a) mem[p] = 16'($urandom);
         v0 = rd(a); v1 = rd(p);
         w0 = ($urandom_range(0, 5) == 0) ? MW : $urandom_range(0, MW - 1);
         w1 = ($urandom_range(0, 5) == 0) ? MW : $urandom_range(0, MW - 1);
         two = o[1]; to0 = w0 >= MW; to1 = two && !to0 && w1 >= MW;
         len0 = to0 ? MW : 1 + w0;
         len1 = (two && !to0) ? (to1 ? MW : 1 + w1) : 0;
         e_cyc = len0 + len1 + (len1 > 0 ? 1 : 0) + 1;
         e_err = to0 || to1;
         if (!to0) m_mdr = (o == 2'b01) ? d : v0;
         if (two && !to0 && !to1) m_mdr = (o == 2'b10) ? v1 : d;
         wr = (o == 2'b01 && !to0) || (o == 2'b11 && !to0 && !to1);
         t = (o == 2'b01) ? a : p;
         access(o, a, d, w0, w1, 1'b1);
         total++; if (cyc !== e_cyc) $display("FAIL rand cycles op=%0d: got %0d want %0d", o, cyc, e_cyc); else passed++;
         total++; if (reqs !== len0 + len1) $display("FAIL rand req cycles op=%0d: got %0d want %0d", o, reqs, len0 + len1); else passed++;
         total++; if (err !== e_err) $display("FAIL rand err op=%0d: got %b want %b", o, err, e_err); else passed++;
         total++; if (mar !== ((two && !to0) ? p : a)) $display("FAIL rand mar op=%0d: got %h want %h", o, mar, (two && !to0) ? p : a); else passed++;
         total++; if (mdr !== m_mdr) $display("FAIL rand mdr op=%0d: got %h want %h", o, mdr, m_mdr); else passed++;
         total++; if (ph_addr[0] !== a || ph_we[0] !== (o == 2'b01)) $display("FAIL rand phase0 op=%0d: got %h/%b want %h/%b", o, ph_addr[0], ph_we[0], a, o == 2'b01); else passed++;
         total++; if (gaps !== (len1 > 0 ? 1 : 0)) $display("FAIL rand gap op=%0d: got %0d want %0d", o, gaps, len1 > 0 ? 1 : 0); else passed++;
         if (len1 > 0) begin
            total++; if (ph_addr[1] !== p || ph_we[1] !== (o == 2'b11)) $display("FAIL rand phase1 op=%0d: got %h/%b want %h/%b", o, ph_addr[1], ph_we[1], p, o == 2'b11); else passed++;
         end
         if (wr) begin
            total++; if (rd(t) !== d) $display("FAIL rand store op=%0d: got %h want %h", o, rd(t), d); else passed++;
         end else begin
            total++; if (rd(a) !== v0) $display("FAIL rand no-store op=%0d: got %h want %h", o, rd(a), v0); else passed++;
         end
         total++; if (glitch !== 0 || busy !== 1'b0) $display("FAIL rand bus hygiene op=%0d: got glitch=%0d busy=%b want 0 0", o, glitch, busy); else passed++;
      end
   endtask
   task automatic test_reset_mid;
      bit found;
      found = 1'b0;
      mem[16'h3030] = 16'h6100; mem[16'h6100] = 16'h0000;
      @(negedge clk);
      start = 1'b1; op = 2'b11; ea = 16'h3030; st_data = 16'h5555;
      @(negedge clk);
      start = 1'b0;
      for (int n = 0; n < 20; n++) begin
         if (bus.mem_we) begin
            found = 1'b1;
            break;
         end
         bus.mem_ready = bus.mem_req; bus.mem_rdata = rd(bus.mem_addr);
         @(negedge clk);
      end
      total++; if (!found) $display("FAIL sti reach write: got no write phase want one"); else passed++;
      bus.mem_ready = 1'b0; start = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      total++; if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0 || busy !== 1'b0) $display("FAIL async reset: got req=%b we=%b busy=%b want 000", bus.mem_req, bus.mem_we, busy); else passed++;
      @(negedge clk);
      total++; if (done !== 1'b0 || mar !== 16'h0 || mdr !== 16'h0 || rd(16'h6100) !== 16'h0) $display("FAIL reset abort: got done=%b mar=%h mdr=%h mem=%h want 0 0 0 0", done, mar, mdr, rd(16'h6100)); else passed++;
      start = 1'b0;
      @(posedge clk); #3 rst_n = 1'b1;
      mem[16'h3040] = 16'hCAFE;
      access(2'b00, 16'h3040, 16'h0, 0, 0, 1'b0);
      total++; if (cyc !== 2 || mdr !== 16'hCAFE) $display("FAIL post-reset ld: got cyc=%0d mdr=%h want 2 cafe", cyc, mdr); else passed++;
   endtask
   initial begin
      clk = 1'b0; rst_n = 1'b0; start = 1'b0; op = '0; ea = '0; st_data = '0;
      bus.mem_ready = 1'b0; bus.mem_rdata = '0;
      total = 0; passed = 0; m_mdr = '0;
      test_reset();
      test_directed();
      test_timeout();
      test_random(60);
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
